// File: rtl/regfile_pkg.sv
// Shared sizing and types for the 32 x 64-bit CPU register file.
// The zero register index is fixed by the ISA, so it is a localparam here.
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 31;

  typedef logic [DATA_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/register_en.sv
// One DATA_WIDTH-bit register with load enable and synchronous reset.
// An unknown load holds the current value, so an X on the write select cannot spread.
module register_en
  import regfile_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Reset wins over load; without load the register recirculates its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: one clocked write port, two combinational read ports,
// register 31 hardwired to zero, optional same-cycle write-to-read forwarding.
module regfile_32x64
  import regfile_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  reg_word_t             write_data,
  input  logic [ADDR_WIDTH-1:0] read_register1,
  input  logic [ADDR_WIDTH-1:0] read_register2,
  output reg_word_t             read_data1,
  output reg_word_t             read_data2
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [NUM_REGS-1:0] w_wr_sel;
  reg_word_t           w_regs [NUM_REGS];
  reg_word_t           w_mux1;
  reg_word_t           w_mux2;
  logic                w_byp1;
  logic                w_byp2;

  // One-hot write decode gated by reg_write; the zero slot has no storage behind it.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == ZERO_REG) begin : g_zero
      assign w_wr_sel[gi] = 1'b0;
      assign w_regs[gi]   = '0;
    end else begin : g_store
      assign w_wr_sel[gi] = reg_write & (write_register == ADDR_WIDTH'(gi));

      register_en #(
        .WIDTH (DATA_WIDTH)
      ) u_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_wr_sel[gi]),
        .i_d    (write_data),
        .o_q    (w_regs[gi])
      );
    end
  end

  assign w_mux1 = w_regs[read_register1];
  assign w_mux2 = w_regs[read_register2];

  // Forwarding only when the write will actually land on this edge.
  assign w_byp1 = BYPASS && reg_write && !reset
                  && (write_register == read_register1)
                  && (write_register != ZERO_ADDR);
  assign w_byp2 = BYPASS && reg_write && !reset
                  && (write_register == read_register2)
                  && (write_register != ZERO_ADDR);

  always_comb begin
    read_data1 = w_mux1;
    read_data2 = w_mux2;
    if (w_byp1) read_data1 = write_data;
    if (w_byp2) read_data2 = write_data;
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench: a forwarding and a non-forwarding register file share stimulus;
// expected reads come from a bench-side register model through a scoreboard queue.
module tb_regfile_32x64;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] nb_read_data1;
  logic [63:0] nb_read_data2;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] n1;
    logic [63:0] n2;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] model [32];

  regfile_32x64 #(.BYPASS(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .read_data1     (read_data1),
    .read_data2     (read_data2)
  );

  regfile_32x64 #(.BYPASS(1'b0)) dut_nb (
    .clk            (clk),
    .reset          (reset),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .read_data1     (nb_read_data1),
    .read_data2     (nb_read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 2 ns later.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    reset          = rst;
    reg_write      = we;
    write_register = wa;
    write_data     = wd;
    read_register1 = ra1;
    read_register2 = ra2;
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd31) return 64'd0;
    if (byp && reg_write && !reset && write_register == ra) return write_data;
    return model[ra];
  endfunction

  function automatic exp_t make_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.e1  = exp_rd(read_register1, 1'b1);
    e.e2  = exp_rd(read_register2, 1'b1);
    e.n1  = exp_rd(read_register1, 1'b0);
    e.n2  = exp_rd(read_register2, 1'b0);
    return e;
  endfunction

  // Advance the model to the state after the coming rising edge.
  task automatic commit();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (reg_write && write_register != 5'd31) begin
      model[write_register] = write_data;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    #2;
    commit();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      sb.push_back(make_exp("reset_sweep"));
      #2;
      e = sb.pop_front();
      tests_run++;
      if (read_data1 !== e.e1) begin tests_failed++; $display("FAIL %s[%0d] rd1 got=%h exp=%h", e.tag, i, read_data1, e.e1); end
      tests_run++;
      if (read_data2 !== e.e2) begin tests_failed++; $display("FAIL %s[%0d] rd2 got=%h exp=%h", e.tag, i, read_data2, e.e2); end
      $display("[TB] reset_sweep ra1=%0d ra2=%0d rd1=%h rd2=%h", i, 31 - i, read_data1, read_data2);
      commit();
    end
  endtask

  task automatic test_write_readback();
    exp_t e;
    logic [4:0] ra1 [4] = '{5'd0, 5'd5, 5'd6, 5'd5};
    logic [4:0] ra2 [4] = '{5'd5, 5'd4, 5'd5, 5'd6};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i == 0), 5'd5, 64'hDEADBEEF_CAFEF00D, ra1[i], ra2[i]);
      sb.push_back(make_exp("write_readback"));
      #2;
      e = sb.pop_front();
      tests_run++;
      if (read_data1 !== e.e1) begin tests_failed++; $display("FAIL %s[%0d] rd1 got=%h exp=%h", e.tag, i, read_data1, e.e1); end
      tests_run++;
      if (read_data2 !== e.e2) begin tests_failed++; $display("FAIL %s[%0d] rd2 got=%h exp=%h", e.tag, i, read_data2, e.e2); end
      tests_run++;
      if (nb_read_data1 !== e.n1) begin tests_failed++; $display("FAIL %s[%0d] nb_rd1 got=%h exp=%h", e.tag, i, nb_read_data1, e.n1); end
      $display("[TB] write_readback step=%0d rd1=%h rd2=%h", i, read_data1, read_data2);
      commit();
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i == 0), 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, (i == 2) ? 5'd5 : 5'd31, 5'd31);
      sb.push_back(make_exp("zero_reg"));
      #2;
      e = sb.pop_front();
      tests_run++;
      if (read_data1 !== e.e1) begin tests_failed++; $display("FAIL %s[%0d] rd1 got=%h exp=%h", e.tag, i, read_data1, e.e1); end
      tests_run++;
      if (read_data2 !== e.e2) begin tests_failed++; $display("FAIL %s[%0d] rd2 got=%h exp=%h", e.tag, i, read_data2, e.e2); end
      tests_run++;
      if (nb_read_data2 !== e.n2) begin tests_failed++; $display("FAIL %s[%0d] nb_rd2 got=%h exp=%h", e.tag, i, nb_read_data2, e.n2); end
      $display("[TB] zero_reg step=%0d rd1=%h rd2=%h", i, read_data1, read_data2);
      commit();
    end
  endtask

  task automatic test_write_gate();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 5'd7, 64'h1234, 5'd7, 5'd7);
      sb.push_back(make_exp("write_gate"));
      #2;
      e = sb.pop_front();
      tests_run++;
      if (read_data1 !== e.e1) begin tests_failed++; $display("FAIL %s[%0d] rd1 got=%h exp=%h", e.tag, i, read_data1, e.e1); end
      tests_run++;
      if (nb_read_data2 !== e.n2) begin tests_failed++; $display("FAIL %s[%0d] nb_rd2 got=%h exp=%h", e.tag, i, nb_read_data2, e.n2); end
      $display("[TB] write_gate step=%0d rd1=%h", i, read_data1);
      commit();
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, (i == 0), 5'd10, 64'hA5A5, 5'd10, 5'd10);
      sb.push_back(make_exp("bypass"));
      #2;
      e = sb.pop_front();
      tests_run++;
      if (read_data1 !== e.e1) begin tests_failed++; $display("FAIL %s[%0d] rd1 got=%h exp=%h", e.tag, i, read_data1, e.e1); end
      tests_run++;
      if (read_data2 !== e.e2) begin tests_failed++; $display("FAIL %s[%0d] rd2 got=%h exp=%h", e.tag, i, read_data2, e.e2); end
      tests_run++;
      if (nb_read_data1 !== e.n1) begin tests_failed++; $display("FAIL %s[%0d] nb_rd1 got=%h exp=%h", e.tag, i, nb_read_data1, e.n1); end
      tests_run++;
      if (nb_read_data2 !== e.n2) begin tests_failed++; $display("FAIL %s[%0d] nb_rd2 got=%h exp=%h", e.tag, i, nb_read_data2, e.n2); end
      $display("[TB] bypass step=%0d rd=%h/%h nb=%h/%h", i, read_data1, read_data2, nb_read_data1, nb_read_data2);
      commit();
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    logic       rst [3] = '{1'b0, 1'b1, 1'b0};
    logic [4:0] ra2 [3] = '{5'd5, 5'd5, 5'd10};
    for (int i = 0; i < 3; i++) begin
      drive(rst[i], (i < 2), 5'd3, (i == 0) ? 64'h55 : 64'h77, 5'd3, ra2[i]);
      sb.push_back(make_exp("reset_priority"));
      #2;
      e = sb.pop_front();
      tests_run++;
      if (read_data1 !== e.e1) begin tests_failed++; $display("FAIL %s[%0d] rd1 got=%h exp=%h", e.tag, i, read_data1, e.e1); end
      tests_run++;
      if (read_data2 !== e.e2) begin tests_failed++; $display("FAIL %s[%0d] rd2 got=%h exp=%h", e.tag, i, read_data2, e.e2); end
      tests_run++;
      if (nb_read_data1 !== e.n1) begin tests_failed++; $display("FAIL %s[%0d] nb_rd1 got=%h exp=%h", e.tag, i, nb_read_data1, e.n1); end
      $display("[TB] reset_priority step=%0d rst=%0d rd1=%h rd2=%h", i, rst[i], read_data1, read_data2);
      commit();
    end
  endtask

  task automatic test_exhaustive();
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      int r = i % 32;
      drive(1'b0, (i < 32), 5'(r), 64'(r) * 64'h0101_0101_0101_0101, 5'(r), 5'((r + 31) % 32));
      sb.push_back(make_exp((i < 32) ? "walk_write" : "walk_read"));
      #2;
      e = sb.pop_front();
      tests_run++;
      if (read_data1 !== e.e1) begin tests_failed++; $display("FAIL %s[%0d] rd1 got=%h exp=%h", e.tag, r, read_data1, e.e1); end
      tests_run++;
      if (read_data2 !== e.e2) begin tests_failed++; $display("FAIL %s[%0d] rd2 got=%h exp=%h", e.tag, r, read_data2, e.e2); end
      tests_run++;
      if (nb_read_data1 !== e.n1) begin tests_failed++; $display("FAIL %s[%0d] nb_rd1 got=%h exp=%h", e.tag, r, nb_read_data1, e.n1); end
      $display("[TB] %s reg=%0d rd1=%h rd2=%h", e.tag, r, read_data1, read_data2);
      commit();
    end
  endtask

  initial begin
    reset          = 1'b1;
    reg_write      = 1'b0;
    write_register = 5'd0;
    write_data     = 64'd0;
    read_register1 = 5'd0;
    read_register2 = 5'd0;
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_write_gate();
    test_bypass();
    test_reset_priority();
    test_exhaustive();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
